// File: rtl/div_pkg.sv
// Shared types and sizing for the MultDiv divide path.
// Imported by the divider and its negation helpers.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        SIGN
    } state_t;

    localparam int DIV_WIDTH  = 32;
    localparam int ITER_COUNT = 32;
    localparam int COUNT_W    = 6;

    localparam logic [COUNT_W-1:0] LAST_STEP = COUNT_W'(ITER_COUNT - 1);

endpackage

// File: rtl/bit32_negate.sv
// Two's-complement negation: invert through bit32_not, then add one.
// Negating 0x80000000 wraps back to itself.
module bit32_negate (
    input  logic [31:0] data_operandA,
    output logic [31:0] data_result
);

    logic [31:0] inv;

    bit32_not u_not (
        .data_operandA(data_operandA),
        .data_result  (inv)
    );

    assign data_result = inv + 32'd1;

endmodule

// File: rtl/bit32_not.sv
// 32-bit bitwise inverter shared across the MultDiv unit.
// Purely combinational.
module bit32_not (
    input  logic [31:0] data_operandA,
    output logic [31:0] data_result
);

    genvar i;
    generate
        for (i = 0; i < 32; i++) begin : g_inv
            assign data_result[i] = ~data_operandA[i];
        end
    endgenerate

endmodule

// File: rtl/bit32_div.sv
// Multicycle signed 32-bit restoring divider, one quotient bit per clock.
// Magnitudes are divided unsigned; signs are restored in the SIGN cycle.
module bit32_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);

    state_t             state;
    logic [COUNT_W-1:0] count;
    logic [31:0]        abs_b;
    logic [31:0]        rem;
    logic [31:0]        quo;
    logic               sign_q;
    logic               sign_r;
    logic               div_zero;

    logic [31:0] neg_a;
    logic [31:0] neg_b;
    logic [31:0] neg_q;
    logic [31:0] neg_r;
    logic [31:0] abs_a_in;
    logic [31:0] abs_b_in;
    logic [31:0] rem_sh;
    logic [31:0] quo_sh;
    logic [32:0] trial;

    bit32_negate u_neg_a (
        .data_operandA(data_operandA),
        .data_result  (neg_a)
    );

    bit32_negate u_neg_b (
        .data_operandA(data_operandB),
        .data_result  (neg_b)
    );

    bit32_negate u_neg_q (
        .data_operandA(quo),
        .data_result  (neg_q)
    );

    bit32_negate u_neg_r (
        .data_operandA(rem),
        .data_result  (neg_r)
    );

    assign abs_a_in = data_operandA[31] ? neg_a : data_operandA;
    assign abs_b_in = data_operandB[31] ? neg_b : data_operandB;

    // rem < |B| <= 2^31, so rem[31] is always zero and the shift loses nothing
    assign {rem_sh, quo_sh} = {rem[30:0], quo, 1'b0};
    assign trial = {1'b0, rem_sh} - {1'b0, abs_b};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            count          <= '0;
            abs_b          <= '0;
            rem            <= '0;
            quo            <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            div_zero       <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (ctrl_DIV) begin
            abs_b          <= abs_b_in;
            quo            <= abs_a_in;
            rem            <= '0;
            count          <= '0;
            sign_q         <= data_operandA[31] ^ data_operandB[31];
            sign_r         <= data_operandA[31];
            div_zero       <= (data_operandB == '0);
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            state          <= (data_operandB == '0) ? SIGN : ITER;
        end else begin
            data_resultRDY <= 1'b0;
            unique case (state)
                IDLE: begin
                    state <= IDLE;
                end
                ITER: begin
                    quo   <= {quo_sh[31:1], ~trial[32]};
                    rem   <= trial[32] ? rem_sh : trial[31:0];
                    count <= count + COUNT_W'(1);
                    if (count == LAST_STEP) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    if (div_zero) begin
                        data_result    <= '0;
                        data_remainder <= '0;
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= sign_q ? neg_q : quo;
                        data_remainder <= sign_r ? neg_r : rem;
                        data_exception <= 1'b0;
                    end
                    data_resultRDY <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit32_div.sv
// Directed-vector bench for bit32_div: latency, signs, overflow,
// divide-by-zero, abort/restart and reset behaviour.
module tb_bit32_div;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;

    int n_chk  = 0;
    int n_pass = 0;

    bit32_div dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_remainder(data_remainder),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents operands for one edge (edge 0) and drops the strobe.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        tick();
        ctrl_DIV = 1'b0;
    endtask

    // Returns the edge count at which ready appeared, or lim+1 if none.
    task automatic wait_rdy(input int lim, output int n);
        n = lim + 1;
        for (int i = 1; i <= lim; i++) begin
            tick();
            if (data_resultRDY) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input logic ee,
                           input int lat);
        int n;
        do_start(a, b);
        wait_rdy(40, n);
        check({tag, "_lat"}, n, lat);
        check({tag, "_q"}, data_result, eq);
        check({tag, "_r"}, data_remainder, er);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
        tick();
        check({tag, "_rdy1"}, {31'd0, data_resultRDY}, 32'd0);
        check({tag, "_hold"}, data_result, eq);
    endtask

    initial begin
        int n;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] eq;
        logic signed [31:0] er;
        logic signed [31:0] gq;
        logic signed [31:0] gr;
        logic [31:0] mag_r;
        logic [31:0] mag_b;

        reset         = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        tick();
        tick();
        check("rst_q", data_result, 32'd0);
        check("rst_r", data_remainder, 32'd0);
        check("rst_exc", {31'd0, data_exception}, 32'd0);
        check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b1;
        tick();

        run_div("p100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run_div("n100_7", 32'hFFFFFF9C, 32'd7,
                32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33);
        run_div("p100_n7", 32'd100, 32'hFFFFFFF9,
                32'hFFFFFFF2, 32'd2, 1'b0, 33);
        run_div("n100_n7", 32'hFFFFFF9C, 32'hFFFFFFF9,
                32'd14, 32'hFFFFFFFE, 1'b0, 33);
        run_div("ovf", 32'h80000000, 32'hFFFFFFFF,
                32'h80000000, 32'd0, 1'b0, 33);
        run_div("min_min", 32'h80000000, 32'h80000000,
                32'd1, 32'd0, 1'b0, 33);
        run_div("max_1", 32'h7FFFFFFF, 32'd1,
                32'h7FFFFFFF, 32'd0, 1'b0, 33);
        run_div("small_big", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33);
        run_div("dz", 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1);

        // Reset clears a held exception flag
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst_after_dz", {31'd0, data_exception}, 32'd0);

        // Abort at edge 10 with new operands
        do_start(32'd100, 32'd7);
        repeat (9) tick();
        do_start(32'd81, 32'd9);
        wait_rdy(40, n);
        check("abort_lat", n, 33);
        check("abort_q", data_result, 32'd9);
        check("abort_r", data_remainder, 32'd0);

        // Restart presented on the SIGN edge wins
        do_start(32'd100, 32'd7);
        repeat (32) tick();
        do_start(32'd81, 32'd9);
        check("sign_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("sign_rst_q", data_result, 32'd0);
        wait_rdy(40, n);
        check("sign_rst_lat", n, 33);
        check("sign_rst_q2", data_result, 32'd9);

        // Reset mid-operation discards it
        do_start(32'd100, 32'd7);
        repeat (19) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_q", data_result, 32'd0);
        check("midrst_r", data_remainder, 32'd0);
        wait_rdy(40, n);
        check("midrst_nordy", n, 41);

        // Reset beats a simultaneous start
        reset         = 1'b0;
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        tick();
        reset    = 1'b1;
        ctrl_DIV = 1'b0;
        wait_rdy(40, n);
        check("rst_vs_start", n, 41);

        // Reset after a completed divide clears held results
        run_div("pre_rst", 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 33);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("postrst_q", data_result, 32'd0);
        check("postrst_r", data_remainder, 32'd0);

        for (int k = 0; k < 8; k++) begin
            sa = $signed($urandom);
            if (k < 4) begin
                sb = $signed($urandom);
            end else begin
                sb = $signed(32'($urandom_range(1, 1000)));
                if (k[0]) sb = -sb;
            end
            if (sb == 0) sb = 1;
            if (sa == 32'sh80000000 && sb == -1) sb = 3;
            eq = sa / sb;
            er = sa % sb;
            do_start(sa, sb);
            wait_rdy(40, n);
            check("rnd_lat", n, 33);
            gq = data_result;
            gr = data_remainder;
            check("rnd_q", gq, eq);
            check("rnd_r", gr, er);
            check("rnd_id", gq * sb + gr, sa);
            mag_r = gr[31] ? -gr : gr;
            mag_b = sb[31] ? -sb : sb;
            check("rnd_mag", {31'd0, (mag_r < mag_b)}, 32'd1);
            check("rnd_sgn", {31'd0, (gr == 0) || (gr[31] == sa[31])}, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bit32_div.md
# bit32_div

Multicycle signed 32-bit divider for the MultDiv unit, the counterpart to the multiplier path. It accepts a start pulse with dividend and divisor, runs one restoring-division step per clock, and returns quotient, remainder, a divide-by-zero exception and a one-cycle ready pulse. Operand and result sign handling uses two's-complement negation built from the unit's existing 32-bit inverter.

## Interface
- WIDTH, 32: operand and result width; only 32 is supported and verified.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low (asserted when 0).
- ctrl_DIV  in  1  start pulse. Operands are sampled on any edge where this is high.
- data_operandA  in  32  dividend, signed two's complement.
- data_operandB  in  32  divisor, signed two's complement.
- data_result  out  32  quotient, truncated toward zero.
- data_remainder  out  32  remainder; its sign equals the dividend's sign.
- data_exception  out  1  divide-by-zero flag.
- data_resultRDY  out  1  result-valid pulse, exactly one cycle wide.

## Operation
- **States:** IDLE, ITER, SIGN.
- **Start (any state):** on an edge with reset high and ctrl_DIV high, the block:
  - latches |A| and |B| (negated if negative);
  - latches signQ = A[31]^B[31] and signR = A[31];
  - clears data_result, data_remainder, data_exception and data_resultRDY;
  - zeroes the 32-bit partial remainder and the 6-bit counter.
- **ctrl_DIV while busy:** aborts the current division and restarts with the new operands. No ready pulse is issued for the aborted operation.
- **Divide by zero:** if B == 0 at start, the block goes directly to SIGN. SIGN then writes data_result=0, data_remainder=0 and data_exception=1.
- **ITER:** each cycle performs one restoring step.
  - Shift {rem, quo} left by 1.
  - Form trial = rem − |B| as 33 bits.
  - If trial is non-negative: rem=trial[31:0] and quo[0]=1. Otherwise rem is unchanged and quo[0]=0.
  - The counter increments each step. After 32 steps the state goes to SIGN.
- **SIGN (one cycle):**
  - data_result = signQ ? −quo : quo.
  - data_remainder = signR ? −rem : rem.
  - data_resultRDY is set. The state returns to IDLE.
- **Overflow:** 0x80000000 / 0xFFFFFFFF wraps to quotient 0x80000000 with remainder 0. No exception is raised.
- **Output hold:** outputs keep their values until the next start or reset. data_resultRDY clears on the edge after it is set.

## Timing
- Count the sampling edge of ctrl_DIV as edge 0.
- **Normal divide:** ITER steps run on edges 1–32. SIGN updates the outputs at edge 33. data_resultRDY is high from edge 33 to edge 34. Latency is 33 cycles.
- **Divide by zero:** outputs and data_resultRDY update at edge 1.
- **Reset** (reset==0 at an edge) overrides everything, including a simultaneous ctrl_DIV. After reset:
  - state is IDLE;
  - data_result, data_remainder and the counter are 0;
  - data_exception and data_resultRDY are 0.
- **Reset mid-operation:** the operation is discarded and no ready pulse follows.
- **Back-to-back starts:** ctrl_DIV held high on consecutive edges restarts on every edge. Only the last start yields a result.
- **ctrl_DIV on the SIGN edge:** the restart wins. The outputs are cleared and no ready pulse is issued.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- **Package div_pkg:**
  - state enum {IDLE, ITER, SIGN};
  - DIV_WIDTH = 32;
  - ITER_COUNT = 32;
  - COUNT_W = 6.
- **Sub-module bit32_negate:** data_result = ~data_operandA + 1, built on bit32_not plus a 32-bit increment.
  - Instantiated for the dividend and divisor absolute values.
  - Instantiated for the quotient and remainder sign fix.
  - Datapath registers, the FSM and the restoring subtractor live in bit32_div.

## Test plan
- 100 / 7 → data_result=14 and data_remainder=2 at edge 33; data_resultRDY high for exactly one cycle; exception 0.
- −100 / 7 → 0xFFFFFFF2 (−14), remainder 0xFFFFFFFE (−2). 100 / −7 → −14, remainder 2.
- 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, exception 0. 5 / 0 → result 0, exception 1, ready at edge 1.
- Start 100/7; pulse ctrl_DIV again at edge 10 with 81/9 → single ready pulse 33 cycles after the second start, quotient 9, remainder 0.
- Start 100/7; drive reset=0 at edge 20 → all outputs 0 at edge 21, no ready pulse within 40 cycles.
- Randomized signed operand pairs (B≠0) → quotient×B + remainder == A, |remainder| < |B|, and remainder sign matches dividend (or remainder is 0).
